// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter: producers push at any rate, the issue
// FSM pops one byte per frame and paces itself on the UART busy/done handshake.
module uart_tx_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              wr_en_i,
    input  logic [7:0]        wr_data_i,
    output logic              full_o,
    output logic              empty_o,
    output logic [ADDR_W:0]   count_o,
    output logic              overflow_o,
    output logic [7:0]        txdata_o,
    output logic              txstart_o,
    input  logic              txbusy_i,
    input  logic              txdone_i
);

    localparam int                  CNT_W   = ADDR_W + 1;
    localparam logic [CNT_W-1:0]    CNT_MAX = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]    CNT_ONE = CNT_W'(1);
    localparam logic [ADDR_W-1:0]   PTR_ONE = ADDR_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         mem_q [DEPTH];
    logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               full_q, full_d;
    logic               empty_q, empty_d;
    logic               overflow_q, overflow_d;
    logic [7:0]         txdata_q, txdata_d;
    logic               txstart_q, txstart_d;
    logic               push_s;
    logic               pop_s;

    // Issue FSM: decides when a stored byte is handed to the UART.
    always_comb begin
        state_d = state_q;
        pop_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!empty_q && !txbusy_i) begin
                    pop_s   = 1'b1;
                    state_d = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // UART busy is deliberately ignored here; only its done pulse matters.
                if (txdone_i) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FIFO bookkeeping and registered status/UART outputs.
    always_comb begin
        // Full is the registered flag, so a push while full is refused even on a pop cycle.
        push_s     = wr_en_i && !full_q;
        overflow_d = wr_en_i && full_q;
        txstart_d  = pop_s;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
            txdata_d = mem_q[rd_ptr_q];
        end else begin
            rd_ptr_d = rd_ptr_q;
            txdata_d = txdata_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
        full_d  = (count_d == CNT_MAX);
        empty_d = (count_d == {CNT_W{1'b0}});
    end

    // State and control registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= {ADDR_W{1'b0}};
            rd_ptr_q   <= {ADDR_W{1'b0}};
            count_q    <= {CNT_W{1'b0}};
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
            txdata_q   <= 8'h00;
            txstart_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            overflow_q <= overflow_d;
            txdata_q   <= txdata_d;
            txstart_q  <= txstart_d;
        end
    end

    // Byte storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clk_i) begin
        if (!reset_i && push_s) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    assign full_o     = full_q;
    assign empty_o    = empty_q;
    assign count_o    = count_q;
    assign overflow_o = overflow_q;
    assign txdata_o   = txdata_q;
    assign txstart_o  = txstart_q;

endmodule
